// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin scheduler that shares one free-running UART
// transmitter between NUM_REQ byte sources. Each granted byte is wrapped in a
// packet (SYNC, channel ID, payload[, checksum]); IDLE_BYTE fills empty frames.
// The scheduler advances one byte per transmitter frame, paced on TC rising.
//
// Build option: UART_SCHED_CHKSUM_EN adds a trailing checksum byte
//   (SYNC_BYTE ^ {4'h0,ch} ^ payload), giving 4-byte packets instead of 3.
//
// Ports:
//   CLK        system clock
//   RST        synchronous, active-high reset
//   REQ_VALID  per-requester byte-valid flags
//   REQ_DATA   flattened payload bytes, requester i at [8i+7:8i]
//   REQ_READY  one-cycle capture pulse for the granted requester
//   TC         transmitter frame-complete flag (asynchronous to the FSM)
//   TX_DATA    byte presented to the transmitter DATA input
//   BUSY       high while a packet is in progress
//   CUR_CH     channel of the packet in progress, 0 when idle
module uart_tx_scheduler #(
    parameter int unsigned NUM_REQ   = 4,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter logic [7:0]  IDLE_BYTE = 8'hFF
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NUM_REQ-1:0]     REQ_VALID,
    input  logic [8*NUM_REQ-1:0]   REQ_DATA,
    output logic [NUM_REQ-1:0]     REQ_READY,
    input  logic                   TC,
    output logic [7:0]             TX_DATA,
    output logic                   BUSY,
    output logic [3:0]             CUR_CH
);

    localparam int unsigned CH_W   = 4;
    localparam int unsigned BYTE_W = 8;

`ifdef UART_SCHED_CHKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SYNC = 3'd1,
        S_ID   = 3'd2,
        S_PAY  = 3'd3,
        S_CHK  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SYNC = 3'd1,
        S_ID   = 3'd2,
        S_PAY  = 3'd3
    } state_t;
`endif

    state_t              state;
    state_t              state_nxt;
    logic [CH_W-1:0]     rr_ptr;
    logic [CH_W-1:0]     rr_ptr_nxt;
    logic [BYTE_W-1:0]   payload;
    logic [BYTE_W-1:0]   payload_nxt;
    logic [BYTE_W-1:0]   tx_data_nxt;
    logic [NUM_REQ-1:0]  req_ready_nxt;
    logic                busy_nxt;
    logic [CH_W-1:0]     cur_ch_nxt;

    logic                tc_s1;
    logic                tc_s2;
    logic                tc_s3;
    logic                tc_rise;

    logic                found;
    logic [CH_W-1:0]     win_ch;
    logic [NUM_REQ-1:0]  win_oh;
    logic [BYTE_W-1:0]   win_data;
    logic                arb;

    // TC rising edge after two-flop synchronisation
    assign tc_rise = tc_s2 & ~tc_s3;

    // Round-robin search: first valid above rr_ptr, then wrap to the lowest valid
    always_comb begin
        found    = 1'b0;
        win_ch   = '0;
        win_oh   = '0;
        win_data = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!found && REQ_VALID[j] && (CH_W'(j) > rr_ptr)) begin
                found    = 1'b1;
                win_ch   = CH_W'(j);
                win_oh   = NUM_REQ'(1) << j;
                win_data = REQ_DATA[BYTE_W*j +: BYTE_W];
            end
        end
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!found && REQ_VALID[j] && (CH_W'(j) <= rr_ptr)) begin
                found    = 1'b1;
                win_ch   = CH_W'(j);
                win_oh   = NUM_REQ'(1) << j;
                win_data = REQ_DATA[BYTE_W*j +: BYTE_W];
            end
        end
    end

    // Next-state and next-output logic; everything holds unless tc_rise
    always_comb begin
        state_nxt     = state;
        rr_ptr_nxt    = rr_ptr;
        payload_nxt   = payload;
        tx_data_nxt   = TX_DATA;
        req_ready_nxt = '0;
        busy_nxt      = BUSY;
        cur_ch_nxt    = CUR_CH;
        arb           = 1'b0;

        if (tc_rise) begin
            case (state)
                S_IDLE: arb = 1'b1;
                S_SYNC: begin
                    state_nxt   = S_ID;
                    tx_data_nxt = {4'h0, CUR_CH};
                end
                S_ID: begin
                    state_nxt   = S_PAY;
                    tx_data_nxt = payload;
                end
`ifdef UART_SCHED_CHKSUM_EN
                S_PAY: begin
                    state_nxt   = S_CHK;
                    tx_data_nxt = SYNC_BYTE ^ {4'h0, CUR_CH} ^ payload;
                end
                S_CHK: arb = 1'b1;
`else
                S_PAY: arb = 1'b1;
`endif
                default: state_nxt = S_IDLE;
            endcase
        end

        // Packet end or idle: start the next packet back-to-back, else fill
        if (arb) begin
            if (found) begin
                state_nxt     = S_SYNC;
                rr_ptr_nxt    = win_ch;
                payload_nxt   = win_data;
                tx_data_nxt   = SYNC_BYTE;
                req_ready_nxt = win_oh;
                busy_nxt      = 1'b1;
                cur_ch_nxt    = win_ch;
            end else begin
                state_nxt   = S_IDLE;
                tx_data_nxt = IDLE_BYTE;
                busy_nxt    = 1'b0;
                cur_ch_nxt  = '0;
            end
        end
    end

    // State, sync flops and registered outputs; sync flops reset high so a TC
    // already high at reset release is not seen as an edge
    always_ff @(posedge CLK) begin
        if (RST) begin
            tc_s1     <= 1'b1;
            tc_s2     <= 1'b1;
            tc_s3     <= 1'b1;
            state     <= S_IDLE;
            rr_ptr    <= CH_W'(NUM_REQ - 1);
            payload   <= '0;
            TX_DATA   <= IDLE_BYTE;
            REQ_READY <= '0;
            BUSY      <= 1'b0;
            CUR_CH    <= '0;
        end else begin
            tc_s1     <= TC;
            tc_s2     <= tc_s1;
            tc_s3     <= tc_s2;
            state     <= state_nxt;
            rr_ptr    <= rr_ptr_nxt;
            payload   <= payload_nxt;
            TX_DATA   <= tx_data_nxt;
            REQ_READY <= req_ready_nxt;
            BUSY      <= busy_nxt;
            CUR_CH    <= cur_ch_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: drives TC frames and requester traffic into
// uart_tx_scheduler and compares every frame against a byte-queue model.
module tb_uart_tx_scheduler;

    localparam int unsigned N    = 4;
    localparam logic [7:0]  SYNC = 8'hA5;
    localparam logic [7:0]  IDLE = 8'hFF;
`ifdef UART_SCHED_CHKSUM_EN
    localparam int PKT = 4;
`else
    localparam int PKT = 3;
`endif

    logic           CLK = 1'b0;
    logic           RST;
    logic           TC;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data_flat;
    logic [N-1:0]   REQ_READY;
    logic [7:0]     TX_DATA;
    logic           BUSY;
    logic [3:0]     CUR_CH;

    logic           req_v [N];
    logic [7:0]     req_d [N];

    for (genvar g = 0; g < N; g++) begin : g_req
        assign req_valid[g]             = req_v[g];
        assign req_data_flat[8*g +: 8]  = req_d[g];
    end

    uart_tx_scheduler #(
        .NUM_REQ   (N),
        .SYNC_BYTE (SYNC),
        .IDLE_BYTE (IDLE)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ_VALID (req_valid),
        .REQ_DATA  (req_data_flat),
        .REQ_READY (REQ_READY),
        .TC        (TC),
        .TX_DATA   (TX_DATA),
        .BUSY      (BUSY),
        .CUR_CH    (CUR_CH)
    );

    always #5 CLK = ~CLK;

    int n_checks;
    int n_errors;

    // Reference model: pending packet bytes, last granted channel, last frame
    logic [7:0] m_q [$];
    int         m_rr;
    logic [3:0] m_ch;
    logic [7:0] exp_prev;
    logic       exp_busy;
    logic [3:0] exp_ch;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // One frame of the model: start a packet if none pending, emit next byte
    task automatic model_rise(output logic [7:0] eb, output logic eby,
                              output logic [3:0] ec, output logic [N-1:0] eg,
                              output int win);
        int c;
        logic [7:0] d;
        win = -1;
        eg  = '0;
        if (m_q.size() == 0) begin
            for (int k = 1; k <= int'(N); k++) begin
                c = (m_rr + k) % int'(N);
                if (win < 0 && req_v[c]) win = c;
            end
            if (win >= 0) begin
                d    = req_d[win];
                m_rr = win;
                m_ch = 4'(win);
                m_q.push_back(SYNC);
                m_q.push_back({4'h0, 4'(win)});
                m_q.push_back(d);
                if (PKT == 4) m_q.push_back(SYNC ^ {4'h0, 4'(win)} ^ d);
                eg = N'(1) << win;
            end
        end
        if (m_q.size() != 0) begin
            eb  = m_q.pop_front();
            eby = 1'b1;
            ec  = m_ch;
        end else begin
            eb  = IDLE;
            eby = 1'b0;
            ec  = 4'h0;
        end
    endtask

    task automatic frame(input int hi, input int lo);
        logic [7:0]   eb;
        logic         eby;
        logic [3:0]   ec;
        logic [N-1:0] eg;
        logic [N-1:0] racc;
        logic [7:0]   tx2;
        int           win;
        int           rcnt;
        int           rfirst;
        model_rise(eb, eby, ec, eg, win);
        TC     = 1'b1;
        racc   = '0;
        rcnt   = 0;
        rfirst = 0;
        tx2    = TX_DATA;
        for (int s = 1; s <= hi; s++) begin
            step();
            if (s == 2) tx2 = TX_DATA;
            if (REQ_READY != '0) begin
                rcnt++;
                racc |= REQ_READY;
                if (rfirst == 0) rfirst = s;
            end
        end
        TC = 1'b0;
        check("tx_before_update", 32'(tx2), 32'(exp_prev));
        check("tx_data", 32'(TX_DATA), 32'(eb));
        check("busy", 32'(BUSY), 32'(eby));
        check("cur_ch", 32'(CUR_CH), 32'(ec));
        check("req_ready", 32'(racc), 32'(eg));
        check("ready_pulses", 32'(rcnt), (win >= 0) ? 32'd1 : 32'd0);
        if (win >= 0) begin
            check("ready_edge", 32'(rfirst), 32'd3);
            req_v[win] = 1'b0;
        end
        exp_prev = eb;
        exp_busy = eby;
        exp_ch   = ec;
        racc     = '0;
        for (int s = 0; s < lo; s++) begin
            step();
            racc |= REQ_READY;
        end
        check("ready_while_low", 32'(racc), 32'd0);
        check("tx_hold_low", 32'(TX_DATA), 32'(eb));
    endtask

    task automatic do_reset(input logic tc_lvl);
        TC  = tc_lvl;
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;
        m_q.delete();
        m_rr     = int'(N) - 1;
        exp_prev = IDLE;
        exp_busy = 1'b0;
        exp_ch   = 4'h0;
        check("rst_tx", 32'(TX_DATA), 32'(IDLE));
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_cur_ch", 32'(CUR_CH), 32'd0);
        check("rst_ready", 32'(REQ_READY), 32'd0);
        if (!tc_lvl) repeat (6) step();
    endtask

    task automatic rand_reqs();
        for (int i = 0; i < int'(N); i++) begin
            if (!req_v[i]) begin
                if ($urandom_range(0, 2) == 0) begin
                    req_d[i] = 8'($urandom);
                    req_v[i] = 1'b1;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                req_v[i] = 1'b0;
            end
        end
    endtask

    int           chg;
    logic [N-1:0] racc_m;

    initial begin
        n_checks = 0;
        n_errors = 0;
        RST      = 1'b0;
        TC       = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            req_v[i] = 1'b0;
            req_d[i] = 8'h00;
        end

        // Idle line after reset
        do_reset(1'b0);
        repeat (5) frame(8, 12);

        // Single request on channel 2
        req_d[2] = 8'h3C;
        req_v[2] = 1'b1;
        repeat (PKT + 2) frame(8, 12);

        // All requesters at once: round-robin, back-to-back packets
        do_reset(1'b0);
        for (int i = 0; i < int'(N); i++) begin
            req_d[i] = 8'h10 + 8'(i);
            req_v[i] = 1'b1;
        end
        repeat (4 * PKT + 1) frame(8, 12);

        // Reset released with TC already high: no spurious edge
        req_d[0] = 8'h5A;
        req_v[0] = 1'b1;
        do_reset(1'b1);
        chg    = 0;
        racc_m = '0;
        repeat (20) begin
            step();
            if (TX_DATA !== IDLE) chg++;
            racc_m |= REQ_READY;
        end
        check("tc_high_rst_tx_changes", 32'(chg), 32'd0);
        check("tc_high_rst_ready", 32'(racc_m), 32'd0);
        check("tc_high_rst_busy", 32'(BUSY), 32'd0);
        TC = 1'b0;
        repeat (6) step();
        repeat (PKT + 1) frame(8, 12);

        // Reset in the middle of a packet, then rr pointer restarts
        do_reset(1'b0);
        req_d[1] = 8'h77;
        req_v[1] = 1'b1;
        repeat (3) frame(8, 12);
        RST = 1'b1;
        step();
        check("rst_mid_tx", 32'(TX_DATA), 32'(IDLE));
        check("rst_mid_busy", 32'(BUSY), 32'd0);
        check("rst_mid_cur_ch", 32'(CUR_CH), 32'd0);
        RST = 1'b0;
        m_q.delete();
        m_rr     = int'(N) - 1;
        exp_prev = IDLE;
        repeat (6) step();
        req_d[1] = 8'h44;
        req_v[1] = 1'b1;
        req_d[3] = 8'h66;
        req_v[3] = 1'b1;
        repeat (2 * PKT + 1) frame(8, 12);

        // TC stuck low mid-packet: outputs freeze, packet resumes afterwards
        req_d[3] = 8'hC3;
        req_v[3] = 1'b1;
        repeat (2) frame(8, 12);
        chg = 0;
        repeat (10000) begin
            step();
            if (TX_DATA !== exp_prev) chg++;
        end
        check("stall_tx_changes", 32'(chg), 32'd0);
        check("stall_busy", 32'(BUSY), 32'(exp_busy));
        check("stall_cur_ch", 32'(CUR_CH), 32'(exp_ch));
        repeat (PKT + 1) frame(8, 12);

        // Random traffic and TC timing
        repeat (150) begin
            rand_reqs();
            frame(int'($urandom_range(4, 12)), int'($urandom_range(5, 20)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
